// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter sharing one combinational barrel shifter between two requesters
module shift_arbiter #(
  parameter int W  = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [W-1:0]  r0_a,
  input  logic [SW-1:0] r0_s,
  input  logic          r0_dir,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [W-1:0]  r1_a,
  input  logic [SW-1:0] r1_s,
  input  logic          r1_dir,
  output logic [W-1:0]  sh_a,
  output logic [SW-1:0] sh_s,
  output logic          sh_dir,
  input  logic [W-1:0]  sh_y,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_y,
  output logic          rsp_id
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nx;
  logic ptr, gnt_any, gnt_id, op_dir, op_id;
  logic [W-1:0] op_a;
  logic [SW-1:0] op_s;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = (state == IDLE)  ? (gnt_any ? ISSUE : IDLE) :
               (state == ISSUE) ? RESP :
               (rsp_ready ? IDLE : RESP);
  end
  // ptr only breaks ties; a lone requester wins regardless of it
  always_comb begin
    gnt_any   = (state == IDLE) && !rst && (r0_valid || r1_valid);
    gnt_id    = (r0_valid && r1_valid) ? ptr : r1_valid;
    r0_ready  = gnt_any && !gnt_id;
    r1_ready  = gnt_any && gnt_id;
    sh_a      = (state == ISSUE) ? op_a : '0;
    sh_s      = (state == ISSUE) ? op_s : '0;
    sh_dir    = (state == ISSUE) && op_dir;
    rsp_valid = (state == RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= 1'b0;
      op_a   <= '0;
      op_s   <= '0;
      op_dir <= 1'b0;
      op_id  <= 1'b0;
      rsp_y  <= '0;
      rsp_id <= 1'b0;
    end else begin
      if (gnt_any) begin
        op_a   <= gnt_id ? r1_a : r0_a;
        op_s   <= gnt_id ? r1_s : r0_s;
        op_dir <= gnt_id ? r1_dir : r0_dir;
        op_id  <= gnt_id;
        ptr    <= !gnt_id;
      end
      if (state == ISSUE) begin
        rsp_y  <= sh_y;
        rsp_id <= op_id;
      end
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed self-checking bench with a behavioural rotator standing in for the shifter
module tb_shift_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic r0_valid = 1'b0, r1_valid = 1'b0, r0_ready, r1_ready;
  logic [7:0] r0_a = '0, r1_a = '0, sh_a, sh_y, rsp_y;
  logic [2:0] r0_s = '0, r1_s = '0, sh_s;
  logic r0_dir = 1'b0, r1_dir = 1'b0, sh_dir;
  logic rsp_valid, rsp_ready = 1'b0, rsp_id;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  function automatic logic [7:0] rot(input logic [7:0] a, input logic [2:0] s, input logic dir);
    logic [15:0] l, r;
    l = {a, a} << s;
    r = {a, a} >> s;
    return dir ? r[7:0] : l[15:8];
  endfunction
  assign sh_y = rot(sh_a, sh_s, sh_dir);
  shift_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_s(r0_s), .r0_dir(r0_dir),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_s(r1_s), .r1_dir(r1_dir),
    .sh_a(sh_a), .sh_s(sh_s), .sh_dir(sh_dir), .sh_y(sh_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic single(input logic id, input logic [7:0] a, input logic [2:0] s, input logic dir, input logic [7:0] y);
    rsp_ready = 1'b0;
    if (id) begin r1_valid = 1'b1; r1_a = a; r1_s = s; r1_dir = dir; end
    else begin r0_valid = 1'b1; r0_a = a; r0_s = s; r0_dir = dir; end
    #1;
    chk("single_ready", {r1_ready, r0_ready}, id ? 2'b10 : 2'b01);
    step();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    chk("issue_ready", {r1_ready, r0_ready}, 2'b00);
    chk("issue_sh", {sh_a, 5'b0, sh_s, 7'b0, sh_dir}, {a, 5'b0, s, 7'b0, dir});
    chk("issue_nvalid", rsp_valid, 1'b0);
    step();
    chk("resp_valid", rsp_valid, 1'b1);
    chk("resp_y", rsp_y, y);
    chk("resp_id", rsp_id, id);
    chk("resp_sh_zero", {sh_a, sh_s, sh_dir}, 0);
    rsp_ready = 1'b1;
    step();
    chk("back_idle", rsp_valid, 1'b0);
  endtask
  initial begin
    step();
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    #1;
    chk("rst_ready", {r1_ready, r0_ready}, 2'b00);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_y}, 0);
    chk("rst_sh", {sh_a, sh_s, sh_dir}, 0);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    step();
    rst = 1'b0;
    single(1'b0, 8'b10010111, 3'd3, 1'b0, 8'b10111100);
    single(1'b1, 8'b01101011, 3'd2, 1'b1, 8'b11011010);
    single(1'b0, 8'h5A, 3'd0, 1'b1, 8'h5A);
    single(1'b1, 8'hC3, 3'd0, 1'b0, 8'hC3);
    // ptr is back at r0: contention must alternate starting with r0
    r0_valid = 1'b1; r0_a = 8'h97; r0_s = 3'd5; r0_dir = 1'b0;
    r1_valid = 1'b1; r1_a = 8'h6B; r1_s = 3'd4; r1_dir = 1'b1;
    rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("cont_grant", {r1_ready, r0_ready}, i[0] ? 2'b10 : 2'b01);
      step();
      chk("cont_issue_ready", {r1_ready, r0_ready}, 2'b00);
      step();
      chk("cont_valid", rsp_valid, 1'b1);
      chk("cont_y", rsp_y, i[0] ? 8'hB6 : 8'hF2);
      chk("cont_id", rsp_id, i[0]);
      step();
    end
    rsp_ready = 1'b0;
    chk("bp_grant", {r1_ready, r0_ready}, 2'b01);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rsp_valid, rsp_id, rsp_y}, {1'b1, 1'b0, 8'hF2});
      chk("bp_ready", {r1_ready, r0_ready}, 2'b00);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_hs_ready", {r1_ready, r0_ready}, 2'b00);
    step();
    chk("bp_next_grant", {r1_ready, r0_ready}, 2'b10);
    step();
    step();
    chk("bp_r1_rsp", {rsp_valid, rsp_id, rsp_y}, {1'b1, 1'b1, 8'hB6});
    step();
    chk("pre_rst_grant", {r1_ready, r0_ready}, 2'b01);
    rsp_ready = 1'b0;
    step();
    step();
    chk("pre_rst_rsp", {rsp_valid, rsp_id, rsp_y}, {1'b1, 1'b0, 8'hF2});
    rst = 1'b1;
    step();
    chk("rst_resp_clear", {rsp_valid, rsp_id, rsp_y}, 0);
    chk("rst_resp_sh", {sh_a, sh_s, sh_dir}, 0);
    chk("rst_resp_ready", {r1_ready, r0_ready}, 2'b00);
    rst = 1'b0;
    #1;
    chk("post_rst_grant", {r1_ready, r0_ready}, 2'b01);
    step();
    chk("post_rst_issue", {sh_a, sh_s, sh_dir}, {8'h97, 3'd5, 1'b0});
    rst = 1'b1;
    step();
    chk("rst_issue_clear", {rsp_valid, sh_a, sh_s, sh_dir}, 0);
    rst = 1'b0;
    step();
    chk("rst_issue_norsp", rsp_valid, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
